// File: rtl/data_memory.sv
// Single-port word memory with byte enables, a registered request/response
// interface, a 1- or 2-cycle read pipeline and a zero-fill engine run after reset or clear.
module data_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  output logic                    busy,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    dbg_in_init,
  output logic [ADDR_WIDTH-1:0]   dbg_init_addr
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // reads then produce exactly one rsp_valid pulse READ_LATENCY cycles later,
  // with no backpressure on the response side.

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic                    fill_we;

  logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NUM_BYTES-1:0]    mem_wbe;

  logic                    in_range;
  logic                    accept;
  logic                    wr_en;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_data;

  logic [READ_LATENCY-1:0]                 rd_valid_q, rd_valid_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    busy        = 1'b0;
    req_ready   = 1'b0;
    fill_we     = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy    = 1'b1;
        fill_we = 1'b1;
        if (clear) begin
          init_addr_d = '0;
        end else if (init_addr_q == LAST_ADDR) begin
          state_d     = ST_READY;
          init_addr_d = '0;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      ST_READY: begin
        req_ready = !clear;
        if (clear) begin
          state_d     = ST_INIT;
          init_addr_d = '0;
        end
      end
    endcase
  end

  // Addresses past RAM_DEPTH drop writes and read back as zero.
  always_comb begin
    in_range = {1'b0, req_addr} < DEPTH_EXT;
    accept   = req_valid && req_ready;
    wr_en    = accept && req_we && in_range;
    rd_en    = accept && !req_we;
    rd_data  = in_range ? mem_q[req_addr[IDX_W-1:0]] : '0;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = req_addr[IDX_W-1:0];
    mem_wdata = req_wdata;
    mem_wbe   = req_be;
    if (fill_we) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr_q[IDX_W-1:0];
      mem_wdata = '0;
      mem_wbe   = '1;
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (mem_wbe[b]) begin
          mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Data registers only load with a valid beat, so the last stage holds the
  // most recent response between pulses.
  always_comb begin
    rd_valid_d    = '0;
    rd_data_d     = rd_data_q;
    rd_valid_d[0] = rd_en;
    if (rd_en) begin
      rd_data_d[0] = rd_data;
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_valid_d[i] = rd_valid_q[i-1];
      if (rd_valid_q[i-1]) begin
        rd_data_d[i] = rd_data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rsp_valid     = rd_valid_q[READ_LATENCY-1];
  assign rsp_rdata     = rd_data_q[READ_LATENCY-1];
  assign dbg_in_init   = (state_q == ST_INIT);
  assign dbg_init_addr = init_addr_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: three instances (16 words/latency 1, 16 words/latency 2,
// 12 words/latency 1) driven with identical requests and checked against array models.
module tb_data_memory;

  localparam int DEPTH [3] = '{16, 16, 12};
  localparam int LAT   [3] = '{1, 2, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;

  logic [2:0]  busy, req_ready, rsp_valid, dbg_in_init;
  logic [31:0] rsp_rdata [3];
  logic [3:0]  dbg_init_addr [3];

  // clock / reset
  always #5 clk = ~clk;

  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(16), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy[0]), .req_valid(req_valid),
    .req_ready(req_ready[0]), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .dbg_in_init(dbg_in_init[0]), .dbg_init_addr(dbg_init_addr[0]));

  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(16), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy[1]), .req_valid(req_valid),
    .req_ready(req_ready[1]), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .dbg_in_init(dbg_in_init[1]), .dbg_init_addr(dbg_init_addr[1]));

  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(12), .READ_LATENCY(1)) u_d12 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy[2]), .req_valid(req_valid),
    .req_ready(req_ready[2]), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
    .dbg_in_init(dbg_in_init[2]), .dbg_init_addr(dbg_init_addr[2]));

  // reference model and scoreboard
  logic [31:0] mdl [3][16];
  logic [31:0] exp_q [3][$];
  int          exp_c [3][$];
  logic [31:0] got_d [3][256];
  int          got_c [3][256];
  int          got_n [3];
  int          bcnt [3];
  int          viol;
  int          cyc;
  int          checks;
  int          errors;

  // One clock: accept decision, model update on the edge, output sampling at negedge.
  task automatic step();
    logic [2:0] acc;
    #1;
    acc = {3{req_valid}} & req_ready;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        while (exp_c[k].size() > 0 && exp_c[k][$] >= cyc) begin
          void'(exp_c[k].pop_back());
          void'(exp_q[k].pop_back());
        end
        for (int a = 0; a < 16; a++) mdl[k][a] = '0;
      end else if (clear) begin
        for (int a = 0; a < 16; a++) mdl[k][a] = '0;
      end else if (acc[k]) begin
        if (req_we) begin
          if (int'(req_addr) < DEPTH[k]) begin
            for (int b = 0; b < 4; b++)
              if (req_be[b]) mdl[k][req_addr][8*b +: 8] = req_wdata[8*b +: 8];
          end
        end else begin
          exp_q[k].push_back((int'(req_addr) < DEPTH[k]) ? mdl[k][req_addr] : 32'h0);
          exp_c[k].push_back(cyc + LAT[k] - 1);
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid[k] && got_n[k] < 256) begin
        got_d[k][got_n[k]] = rsp_rdata[k];
        got_c[k][got_n[k]] = cyc;
        got_n[k]++;
      end
      if (busy[k]) bcnt[k]++;
      if (busy[k] && req_ready[k]) viol++;
    end
  endtask

  // driver
  task automatic drive_cycle(input logic v, input logic we, input logic [3:0] a,
                             input logic [31:0] d, input logic [3:0] be, input logic clr);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    clear     = clr;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic wait_fill();
    for (int i = 0; i < 40 && (busy != 3'b000); i++) idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    for (int k = 0; k < 3; k++) bcnt[k] = 0;
    idle(1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy[k], req_ready[k], rsp_valid[k], rsp_rdata[k], dbg_in_init[k], dbg_init_addr[k]}
          !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'h0}) begin
        errors++;
        $display("FAIL reset_values inst %0d: busy=%b ready=%b valid=%b rdata=%h init=%b iaddr=%0d",
                 k, busy[k], req_ready[k], rsp_valid[k], rsp_rdata[k], dbg_in_init[k], dbg_init_addr[k]);
      end
    end
    rst = 1'b0;
    wait_fill();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bcnt[k] !== DEPTH[k] || req_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL fill_cycles inst %0d: busy cycles %0d ready %b, expected %0d and 1",
                 k, bcnt[k], req_ready[k], DEPTH[k]);
      end
    end
  endtask

  task automatic test_fill_reads();
    logic [31:0] ed;
    int          ec;
    for (int a = 0; a < 16; a++) drive_cycle(1'b1, 1'b0, 4'(a), 32'h0, 4'h0, 1'b0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_n[k] !== exp_q[k].size()) begin
        errors++;
        $display("FAIL fill_reads_count inst %0d: got %0d expected %0d", k, got_n[k], exp_q[k].size());
      end
      for (int i = 0; i < got_n[k] && exp_q[k].size() > 0; i++) begin
        ed = exp_q[k].pop_front();
        ec = exp_c[k].pop_front();
        checks++;
        if (got_d[k][i] !== ed || got_c[k][i] !== ec) begin
          errors++;
          $display("FAIL fill_reads inst %0d #%0d: got %h@%0d expected %h@%0d", k, i, got_d[k][i], got_c[k][i], ed, ec);
        end
      end
      exp_q[k].delete(); exp_c[k].delete(); got_n[k] = 0;
    end
  endtask

  task automatic test_byte_merge();
    logic [31:0] ed;
    int          ec;
    int          acc_cyc;
    drive_cycle(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0);
    drive_cycle(1'b1, 1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0);
    drive_cycle(1'b1, 1'b0, 4'd3, 32'h0, 4'h0, 1'b0);
    acc_cyc = cyc;
    drive_cycle(1'b1, 1'b1, 4'd3, 32'h99999999, 4'b0000, 1'b0);
    drive_cycle(1'b1, 1'b0, 4'd3, 32'h0, 4'h0, 1'b0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_n[k] !== 2 || got_d[k][0] !== 32'hAA22CC44 || got_c[k][0] !== acc_cyc + LAT[k] - 1) begin
        errors++;
        $display("FAIL byte_merge inst %0d: n=%0d data %h@%0d expected 2 AA22CC44@%0d",
                 k, got_n[k], got_d[k][0], got_c[k][0], acc_cyc + LAT[k] - 1);
      end
      for (int i = 0; i < got_n[k] && exp_q[k].size() > 0; i++) begin
        ed = exp_q[k].pop_front();
        ec = exp_c[k].pop_front();
        checks++;
        if (got_d[k][i] !== ed || got_c[k][i] !== ec) begin
          errors++;
          $display("FAIL byte_merge_model inst %0d #%0d: got %h@%0d expected %h@%0d", k, i, got_d[k][i], got_c[k][i], ed, ec);
        end
      end
      exp_q[k].delete(); exp_c[k].delete(); got_n[k] = 0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed;
    int          ec;
    drive_cycle(1'b1, 1'b1, 4'd7, 32'h5, 4'b1111, 1'b0);
    drive_cycle(1'b1, 1'b0, 4'd7, 32'h0, 4'h0, 1'b0);
    drive_cycle(1'b1, 1'b0, 4'd8, 32'h0, 4'h0, 1'b0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_n[k] !== 2 || got_d[k][0] !== 32'h5 || got_d[k][1] !== 32'h0 || got_c[k][1] !== got_c[k][0] + 1) begin
        errors++;
        $display("FAIL back_to_back inst %0d: n=%0d %h@%0d %h@%0d expected 5 then 0 consecutive",
                 k, got_n[k], got_d[k][0], got_c[k][0], got_d[k][1], got_c[k][1]);
      end
      for (int i = 0; i < got_n[k] && exp_q[k].size() > 0; i++) begin
        ed = exp_q[k].pop_front();
        ec = exp_c[k].pop_front();
        checks++;
        if (got_d[k][i] !== ed || got_c[k][i] !== ec) begin
          errors++;
          $display("FAIL back_to_back_model inst %0d #%0d: got %h@%0d expected %h@%0d", k, i, got_d[k][i], got_c[k][i], ed, ec);
        end
      end
      exp_q[k].delete(); exp_c[k].delete(); got_n[k] = 0;
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] ed;
    int          ec;
    drive_cycle(1'b1, 1'b1, 4'd13, 32'hFFFFFFFF, 4'b1111, 1'b0);
    drive_cycle(1'b1, 1'b0, 4'd13, 32'h0, 4'h0, 1'b0);
    for (int a = 0; a < 12; a++) drive_cycle(1'b1, 1'b0, 4'(a), 32'h0, 4'h0, 1'b0);
    idle(4);
    checks++;
    if (got_d[2][0] !== 32'h0) begin
      errors++;
      $display("FAIL oor_read inst 2: got %h expected 00000000", got_d[2][0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_n[k] !== exp_q[k].size()) begin
        errors++;
        $display("FAIL oor_count inst %0d: got %0d expected %0d", k, got_n[k], exp_q[k].size());
      end
      for (int i = 0; i < got_n[k] && exp_q[k].size() > 0; i++) begin
        ed = exp_q[k].pop_front();
        ec = exp_c[k].pop_front();
        checks++;
        if (got_d[k][i] !== ed || got_c[k][i] !== ec) begin
          errors++;
          $display("FAIL oor_model inst %0d #%0d: got %h@%0d expected %h@%0d", k, i, got_d[k][i], got_c[k][i], ed, ec);
        end
      end
      exp_q[k].delete(); exp_c[k].delete(); got_n[k] = 0;
    end
  endtask

  task automatic test_random();
    logic [31:0] ed;
    int          ec;
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 50; n++)
        drive_cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
      idle(4);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_n[k] !== exp_q[k].size()) begin
          errors++;
          $display("FAIL random_count round %0d inst %0d: got %0d expected %0d", r, k, got_n[k], exp_q[k].size());
        end
        for (int i = 0; i < got_n[k] && exp_q[k].size() > 0; i++) begin
          ed = exp_q[k].pop_front();
          ec = exp_c[k].pop_front();
          checks++;
          if (got_d[k][i] !== ed || got_c[k][i] !== ec) begin
            errors++;
            $display("FAIL random round %0d inst %0d #%0d: got %h@%0d expected %h@%0d", r, k, i, got_d[k][i], got_c[k][i], ed, ec);
          end
        end
        exp_q[k].delete(); exp_c[k].delete(); got_n[k] = 0;
      end
    end
  endtask

  task automatic test_clear_inflight();
    logic [31:0] ed;
    int          ec;
    for (int a = 0; a < 4; a++) drive_cycle(1'b1, 1'b1, 4'(a), $urandom | 32'h1, 4'b1111, 1'b0);
    drive_cycle(1'b1, 1'b0, 4'd2, 32'h0, 4'h0, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1; clear = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL clear_blocks_ready: ready=%b expected 000", req_ready);
    end
    for (int k = 0; k < 3; k++) bcnt[k] = 0;
    step();
    clear = 1'b0; req_valid = 1'b0;
    wait_fill();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bcnt[k] !== DEPTH[k]) begin
        errors++;
        $display("FAIL clear_fill_cycles inst %0d: got %0d expected %0d", k, bcnt[k], DEPTH[k]);
      end
    end
    for (int a = 0; a < 4; a++) drive_cycle(1'b1, 1'b0, 4'(a), 32'h0, 4'h0, 1'b0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_n[k] !== exp_q[k].size()) begin
        errors++;
        $display("FAIL clear_count inst %0d: got %0d expected %0d", k, got_n[k], exp_q[k].size());
      end
      for (int i = 0; i < got_n[k] && exp_q[k].size() > 0; i++) begin
        ed = exp_q[k].pop_front();
        ec = exp_c[k].pop_front();
        checks++;
        if (got_d[k][i] !== ed || got_c[k][i] !== ec) begin
          errors++;
          $display("FAIL clear_model inst %0d #%0d: got %h@%0d expected %h@%0d", k, i, got_d[k][i], got_c[k][i], ed, ec);
        end
      end
      exp_q[k].delete(); exp_c[k].delete(); got_n[k] = 0;
    end
  endtask

  task automatic test_clear_in_init();
    for (int k = 0; k < 3; k++) bcnt[k] = 0;
    drive_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1);
    idle(5);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dbg_init_addr[k] !== 4'd5) begin
        errors++;
        $display("FAIL init_progress inst %0d: got %0d expected 5", k, dbg_init_addr[k]);
      end
    end
    drive_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dbg_init_addr[k] !== 4'd0 || busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL init_restart inst %0d: iaddr %0d busy %b expected 0 1", k, dbg_init_addr[k], busy[k]);
      end
    end
    wait_fill();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bcnt[k] !== DEPTH[k] + 6) begin
        errors++;
        $display("FAIL restart_fill_cycles inst %0d: got %0d expected %0d", k, bcnt[k], DEPTH[k] + 6);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] ed;
    int          ec;
    drive_cycle(1'b1, 1'b1, 4'd5, 32'hC0FFEE01, 4'b1111, 1'b0);
    drive_cycle(1'b1, 1'b0, 4'd5, 32'h0, 4'h0, 1'b0);
    rst = 1'b1;
    idle(1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy[k], req_ready[k], rsp_valid[k], rsp_rdata[k], dbg_in_init[k], dbg_init_addr[k]}
          !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'h0}) begin
        errors++;
        $display("FAIL midflight_reset_values inst %0d: busy=%b ready=%b valid=%b rdata=%h init=%b iaddr=%0d",
                 k, busy[k], req_ready[k], rsp_valid[k], rsp_rdata[k], dbg_in_init[k], dbg_init_addr[k]);
      end
    end
    for (int k = 0; k < 3; k++) bcnt[k] = 0;
    idle(1);
    rst = 1'b0;
    wait_fill();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bcnt[k] !== DEPTH[k]) begin
        errors++;
        $display("FAIL midflight_fill_cycles inst %0d: got %0d expected %0d", k, bcnt[k], DEPTH[k]);
      end
    end
    drive_cycle(1'b1, 1'b0, 4'd5, 32'h0, 4'h0, 1'b0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_n[k] !== exp_q[k].size()) begin
        errors++;
        $display("FAIL midflight_count inst %0d: got %0d expected %0d", k, got_n[k], exp_q[k].size());
      end
      for (int i = 0; i < got_n[k] && exp_q[k].size() > 0; i++) begin
        ed = exp_q[k].pop_front();
        ec = exp_c[k].pop_front();
        checks++;
        if (got_d[k][i] !== ed || got_c[k][i] !== ec) begin
          errors++;
          $display("FAIL midflight_model inst %0d #%0d: got %h@%0d expected %h@%0d", k, i, got_d[k][i], got_c[k][i], ed, ec);
        end
      end
      exp_q[k].delete(); exp_c[k].delete(); got_n[k] = 0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    viol   = 0;
    for (int k = 0; k < 3; k++) begin
      got_n[k] = 0;
      bcnt[k]  = 0;
      for (int a = 0; a < 16; a++) mdl[k][a] = '0;
    end
    test_reset();
    test_fill_reads();
    test_byte_merge();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_clear_inflight();
    test_clear_in_init();
    test_reset_midflight();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL busy_and_ready: %0d cycles with both high, expected 0", viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
